register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 105 ++++++++++
 tb/tb_register_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Register bank: NREG = 2**ADDR_W registers of DATA_W bits, index 0 hardwired
// to zero, two combinational read ports, one synchronous write port and an
// 8-bit wrapping count of committed writes.
// Optional write-to-read forwarding is enabled with `define REGBANK_BYPASS_EN.

// One storage register; cleared by the asynchronous reset.
module register_bank_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] q_q;

  // Capture the write data when this register is selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= '0;
    else if (we) q_q <= d;
  end

  assign q = q_q;
endmodule

module register_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [7:0]        wr_count
);
  localparam int NREG = 2**ADDR_W;

  // Storage for indices 1..NREG-1 only; index 0 has no flops.
  logic [NREG-1:1][DATA_W-1:0] regs;
  logic [NREG-1:1]             we_vec;
  logic                        commit;
  logic [7:0]                  wr_count_q, wr_count_d;
  logic [DATA_W-1:0]           rd1, rd2;
  logic                        byp1, byp2;

  // wr_en gates the decode first, so an unknown rd_addr cannot reach any
  // register while writes are disabled.
  assign commit = wr_en & (rd_addr != '0);

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_reg
      assign we_vec[i] = wr_en & (rd_addr == ADDR_W'(i));
      register_bank_cell #(.DATA_W(DATA_W)) u_cell (
        .clk (clk),
        .rst (rst),
        .we  (we_vec[i]),
        .d   (wr_data),
        .q   (regs[i])
      );
    end
  endgenerate

  // Combinational read mux for both ports; index 0 falls through to zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs_addr == ADDR_W'(i)) rd1 = regs[i];
      if (rt_addr == ADDR_W'(i)) rd2 = regs[i];
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Forward the in-flight write to a reader of the same nonzero index.
  assign byp1 = wr_en & ~rst & (rs_addr != '0) & (rs_addr == rd_addr);
  assign byp2 = wr_en & ~rst & (rt_addr != '0) & (rt_addr == rd_addr);
`else
  // Readers see the stored value until the committing edge.
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign reg1 = byp1 ? wr_data : rd1;
  assign reg2 = byp2 ? wr_data : rd2;

  // Next write count: +1 per committed write, natural 8-bit wrap.
  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) wr_count_d = wr_count_q + 8'd1;
  end

  // Write-count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] reg1, reg2, wr_count;

  int ntests = 0;
  int nfail  = 0;

  // Behavioural model: plain array of register values plus a write counter.
  logic [7:0] mem [4];
  int         cnt;

  register_bank #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_data(wr_data),
    .reg1(reg1), .reg2(reg2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] rd;
    logic [7:0] wd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [7:0] e1;   // reg1 before the edge, without forwarding
    logic [7:0] e2;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] rd, input logic [7:0] wd,
                       input logic [1:0] rs, input logic [1:0] rt);
    @(negedge clk);
    wr_en = we; rd_addr = rd; wr_data = wd; rs_addr = rs; rt_addr = rt;
    #1;
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] a, input logic we,
                                          input logic [1:0] rd, input logic [7:0] wd);
    logic [7:0] v;
    v = (a == 2'd0) ? 8'h00 : mem[a];
    if (BYP && we && rd != 2'd0 && rd == a) v = wd;
    return v;
  endfunction

  // Drive one cycle, check pre-edge outputs against the model, then commit.
  task automatic step(input logic we, input logic [1:0] rd, input logic [7:0] wd,
                      input logic [1:0] rs, input logic [1:0] rt);
    drive(we, rd, wd, rs, rt);
    chk("rand_reg1", reg1, model_rd(rs, we, rd, wd));
    chk("rand_reg2", reg2, model_rd(rt, we, rd, wd));
    chk("rand_cnt", wr_count, 8'(cnt));
    if (we && rd != 2'd0) begin
      mem[rd] = wd;
      cnt = (cnt + 1) % 256;
    end
  endtask

  initial begin
    logic [7:0] e1, e2;
    logic [7:0] last;

    tbl[0] = '{1'b1, 2'd1, 8'h5A, 2'd1, 2'd2, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 2'd2, 8'hC3, 2'd1, 2'd2, 8'h5A, 8'h00, 8'h01};
    tbl[2] = '{1'b0, 2'd3, 8'hEE, 2'd1, 2'd2, 8'h5A, 8'hC3, 8'h02};
    tbl[3] = '{1'b1, 2'd0, 8'hFF, 2'd0, 2'd1, 8'h00, 8'h5A, 8'h02};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 8'h00, 8'h00, 8'h02};
    tbl[5] = '{1'b1, 2'd3, 8'h10, 2'd2, 2'd2, 8'hC3, 8'hC3, 8'h02};
    tbl[6] = '{1'b1, 2'd3, 8'h20, 2'd3, 2'd0, 8'h10, 8'h00, 8'h03};
    tbl[7] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'h20, 8'h20, 8'h04};

    // Reads during reset: every index reads zero.
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rs_addr = 2'(a); rt_addr = 2'(3 - a);
      #1;
      chk("rst_reg1", reg1, 8'h00);
      chk("rst_reg2", reg2, 8'h00);
    end
    chk("rst_cnt", wr_count, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    // First cycle after reset still reads zero everywhere.
    for (int a = 0; a < 4; a++) begin
      rs_addr = 2'(a); rt_addr = 2'(a);
      #1;
      chk("post_rst_reg1", reg1, 8'h00);
      chk("post_rst_reg2", reg2, 8'h00);
    end

    // Directed table: writes, rd=0 discard, wr_en=0 hold, same-cycle read of written index.
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].we, tbl[k].rd, tbl[k].wd, tbl[k].rs, tbl[k].rt);
      e1 = tbl[k].e1; e2 = tbl[k].e2;
      if (BYP && tbl[k].we && tbl[k].rd != 2'd0 && tbl[k].rd == tbl[k].rs) e1 = tbl[k].wd;
      if (BYP && tbl[k].we && tbl[k].rd != 2'd0 && tbl[k].rd == tbl[k].rt) e2 = tbl[k].wd;
      chk($sformatf("tbl%0d_reg1", k), reg1, e1);
      chk($sformatf("tbl%0d_reg2", k), reg2, e2);
      chk($sformatf("tbl%0d_cnt", k), wr_count, tbl[k].ec);
    end

    // Mid-cycle reset pulse clears storage without a clock edge.
    drive(1'b1, 2'd1, 8'h77, 2'd1, 2'd0);
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd0);
    chk("r1_77", reg1, 8'h77);
    rst = 1'b1;
    #1;
    chk("async_rst_reg1", reg1, 8'h00);
    chk("async_rst_cnt", wr_count, 8'h00);
    #1;
    rst = 1'b0;
    // The first edge after deassertion commits.
    drive(1'b1, 2'd1, 8'h42, 2'd1, 2'd1);
    chk("first_wr_pre", reg1, BYP ? 8'h42 : 8'h00);
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd1);
    chk("first_wr_post", reg1, 8'h42);
    chk("first_wr_cnt", wr_count, 8'h01);

    // A write whose edge coincides with reset assertion is discarded.
    drive(1'b1, 2'd2, 8'hAB, 2'd2, 2'd1);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("coincide_reg2", reg2, 8'h00);
    chk("coincide_reg1", reg1, 8'h00);
    chk("coincide_cnt", wr_count, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;

    // Randomized traffic against the model; wr_en=0 cycles drive X on rd_addr.
    for (int a = 0; a < 4; a++) mem[a] = 8'h00;
    cnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic       we;
      logic [1:0] rd;
      we = 1'($urandom_range(0, 1));
      rd = 2'($urandom_range(0, 3));
      if (!we && ($urandom_range(0, 3) == 0)) rd = 2'bxx;
      step(we, rd, 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // 256 writes to r2 from reset: counter wraps to 0, r2 keeps the last value.
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      last = 8'((i * 3) + 1);
      drive(1'b1, 2'd2, last, 2'd2, 2'd0);
      if (i == 255) chk("cnt_255", wr_count, 8'hFF);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd2);
    chk("wrap_cnt", wr_count, 8'h00);
    chk("wrap_reg1", reg1, last);
    chk("wrap_reg2", reg2, last);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
